// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Purpose  : In-order retirement buffer. Allocates entries at the tail for
//            issued instructions, captures writeback results, serves operand
//            reads for renamed registers and retires finished entries from
//            the head onto a registered commit port.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int XLEN            = 32,
    parameter int REG_INDEX_WIDTH = 5,
    parameter int ROB_INDEX_WIDTH = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,

    input  logic                       issue_valid,
    input  logic [REG_INDEX_WIDTH-1:0] issue_dest_reg,
    output logic                       issue_ready,
    output logic [ROB_INDEX_WIDTH-1:0] issue_ROB_index,

    output logic                       update_enable,
    output logic [REG_INDEX_WIDTH-1:0] update_dest_reg,
    output logic [ROB_INDEX_WIDTH-1:0] update_ROB_index,

    input  logic                       writeback_valid,
    input  logic [ROB_INDEX_WIDTH-1:0] writeback_ROB_index,
    input  logic [XLEN-1:0]            writeback_data,

    input  logic [ROB_INDEX_WIDTH-1:0] read_ROB1,
    output logic                       read_ROB1_ready,
    output logic [XLEN-1:0]            read_ROB1_data,
    input  logic [ROB_INDEX_WIDTH-1:0] read_ROB2,
    output logic                       read_ROB2_ready,
    output logic [XLEN-1:0]            read_ROB2_data,

    output logic                       commit_enable,
    output logic [REG_INDEX_WIDTH-1:0] commit_sel,
    output logic [XLEN-1:0]            commit_data,
    output logic [ROB_INDEX_WIDTH-1:0] commit_ROB_index
);

    localparam int DEPTH = 1 << ROB_INDEX_WIDTH;
    localparam logic [ROB_INDEX_WIDTH:0] COUNT_FULL = {1'b1, {ROB_INDEX_WIDTH{1'b0}}};

    logic [DEPTH-1:0]           valid;
    logic [DEPTH-1:0]           done;
    logic [REG_INDEX_WIDTH-1:0] dest_mem [DEPTH];
    logic [XLEN-1:0]            data_mem [DEPTH];
    logic [ROB_INDEX_WIDTH-1:0] head;
    logic [ROB_INDEX_WIDTH-1:0] tail;
    logic [ROB_INDEX_WIDTH:0]   count;

    logic alloc;
    logic retire;
    logic wb_write;

    // Full test uses the current count, so a same-cycle retire never frees a slot early
    assign issue_ready      = (count != COUNT_FULL) & ~flush;
    assign issue_ROB_index  = tail;
    assign alloc            = issue_valid & issue_ready;
    assign update_enable    = alloc & (issue_dest_reg != '0);
    assign update_dest_reg  = issue_dest_reg;
    assign update_ROB_index = tail;

    // Results aimed at unallocated entries are dropped
    assign wb_write = writeback_valid & valid[writeback_ROB_index] & ~flush;
    assign retire   = valid[head] & done[head] & ~flush;

    // Control state: valid/done flags, pointers, occupancy and commit port
    always_ff @(posedge clock) begin
        if (reset) begin
            valid            <= '0;
            done             <= '0;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            commit_enable    <= 1'b0;
            commit_sel       <= '0;
            commit_data      <= '0;
            commit_ROB_index <= '0;
        end else if (flush) begin
            valid         <= '0;
            done          <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            commit_enable <= 1'b0;
        end else begin
            if (wb_write) begin
                done[writeback_ROB_index] <= 1'b1;
            end
            // Allocation slot is never the head being retired: tail==head
            // only when empty (no retire) or full (no allocation)
            if (alloc) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
                tail        <= tail + 1'b1;
            end
            // Placed after the writeback update so the clear wins on the head
            if (retire) begin
                valid[head]      <= 1'b0;
                done[head]       <= 1'b0;
                head             <= head + 1'b1;
                commit_sel       <= dest_mem[head];
                commit_data      <= data_mem[head];
                commit_ROB_index <= head;
                commit_enable    <= (dest_mem[head] != '0);
            end else begin
                commit_enable <= 1'b0;
            end
            case ({alloc, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage; contents are only observed behind valid/done
    always_ff @(posedge clock) begin
        if (alloc) begin
            dest_mem[tail] <= issue_dest_reg;
        end
        if (wb_write) begin
            data_mem[writeback_ROB_index] <= writeback_data;
        end
    end

    // Operand read port 1 with same-cycle writeback bypass
    always_comb begin
        read_ROB1_ready = 1'b0;
        read_ROB1_data  = '0;
        if (valid[read_ROB1] && done[read_ROB1]) begin
            read_ROB1_ready = 1'b1;
            read_ROB1_data  = data_mem[read_ROB1];
        end else if (writeback_valid && (writeback_ROB_index == read_ROB1) && valid[read_ROB1]) begin
            read_ROB1_ready = 1'b1;
            read_ROB1_data  = writeback_data;
        end
    end

    // Operand read port 2 with same-cycle writeback bypass
    always_comb begin
        read_ROB2_ready = 1'b0;
        read_ROB2_data  = '0;
        if (valid[read_ROB2] && done[read_ROB2]) begin
            read_ROB2_ready = 1'b1;
            read_ROB2_data  = data_mem[read_ROB2];
        end else if (writeback_valid && (writeback_ROB_index == read_ROB2) && valid[read_ROB2]) begin
            read_ROB2_ready = 1'b1;
            read_ROB2_data  = writeback_data;
        end
    end

endmodule
`default_nettype wire
